// File: rtl/crc4_check.sv
// Bit-serial CRC checker: divides a {data, crc} codeword by a captured generator
// and reports data, syndrome and pass/fail once the last bit has been accepted.
module crc4_check #(
  parameter int WCODE = 5,
  parameter int WPOLY = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_sof,
  input  logic [WPOLY-1:0] i_poly,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_crc_ok,
  output logic [WPOLY-2:0] o_syndrome,
  output logic [WCODE-1:0] o_data,
  output logic             o_frame_err
);

  localparam int LEN = WCODE + WPOLY - 1;
  localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] WCODE_C = CW'(WCODE);
  localparam logic [CW-1:0] LAST_C  = CW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  state_t           state;
  logic [WPOLY-2:0] poly_q;
  logic [WPOLY-2:0] lfsr;
  logic [WCODE-1:0] data_sr;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WPOLY-2:0] lfsr_base;
  logic [WPOLY-2:0] poly_sel;
  logic [WPOLY-2:0] lfsr_next;
  logic [WCODE-1:0] data_next;
  logic [CW-1:0]    cnt_next;

  assign accept = i_valid && o_ready;

  // An SOF bit always restarts the division from a zero remainder, whether the
  // checker was idle or mid-frame, so both cases share the same next-state terms.
  always_comb begin
    lfsr_base = i_sof ? '0 : lfsr;
    poly_sel  = i_sof ? i_poly[WPOLY-2:0] : poly_q;
    lfsr_next = {lfsr_base[WPOLY-3:0], i_bit}
              ^ (lfsr_base[WPOLY-2] ? poly_sel : '0);

    data_next = data_sr;
    if (i_sof) begin
      data_next = {{(WCODE-1){1'b0}}, i_bit};
    end else if (cnt < WCODE_C) begin
      data_next = {data_sr[WCODE-2:0], i_bit};
    end

    cnt_next = i_sof ? CW'(1) : cnt + CW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      poly_q      <= '0;
      lfsr        <= '0;
      data_sr     <= '0;
      cnt         <= '0;
      o_ready     <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_crc_ok    <= 1'b0;
      o_syndrome  <= '0;
      o_data      <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && i_sof) begin
            poly_q  <= i_poly[WPOLY-2:0];
            lfsr    <= lfsr_next;
            data_sr <= data_next;
            cnt     <= cnt_next;
            state   <= RECV;
            o_busy  <= 1'b1;
          end
        end
        RECV: begin
          if (accept) begin
            lfsr    <= lfsr_next;
            data_sr <= data_next;
            cnt     <= cnt_next;
            if (i_sof) begin
              poly_q      <= i_poly[WPOLY-2:0];
              o_frame_err <= 1'b1;
            end else if (cnt == LAST_C) begin
              // Results are taken from the next-state terms so they appear with o_done.
              state      <= DONE;
              o_busy     <= 1'b0;
              o_ready    <= 1'b0;
              o_done     <= 1'b1;
              o_crc_ok   <= (lfsr_next == '0);
              o_syndrome <= lfsr_next;
              o_data     <= data_next;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc4_check.sv
// Self-checking bench for crc4_check: directed frames plus randomized frames
// checked against a polynomial long-division reference.
module tb_crc4_check;

  localparam int WCODE = 5;
  localparam int WPOLY = 4;
  localparam int LEN   = WCODE + WPOLY - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       bitv;
  logic       sof;
  logic [3:0] poly;
  logic       ready;
  logic       busy;
  logic       done;
  logic       crc_ok;
  logic [2:0] syndrome;
  logic [4:0] data;
  logic       frame_err;

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int ferr_cnt   = 0;
  int ready_bad  = 0;

  crc4_check #(.WCODE(WCODE), .WPOLY(WPOLY)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .i_bit      (bitv),
    .i_sof      (sof),
    .i_poly     (poly),
    .o_ready    (ready),
    .o_busy     (busy),
    .o_done     (done),
    .o_crc_ok   (crc_ok),
    .o_syndrome (syndrome),
    .o_data     (data),
    .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (ready === done) ready_bad++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Remainder of cw(x) mod g(x) by long division; g's top bit is always 1.
  function automatic logic [2:0] ref_rem(input logic [7:0] cw, input logic [3:0] p);
    logic [7:0] v;
    logic [7:0] g;
    v = cw;
    g = {4'b0000, 1'b1, p[2:0]};
    for (int i = LEN - 1; i >= WPOLY - 1; i--) begin
      if (v[i]) v = v ^ (g << (i - (WPOLY - 1)));
    end
    return v[2:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic s);
    logic acc;
    acc   = 1'b0;
    valid = 1'b1;
    bitv  = b;
    sof   = s;
    for (int k = 0; k < 4 && !acc; k++) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
    end
    check("bit_accepted", acc, 1'b1);
    valid = 1'b0;
    bitv  = 1'($urandom);
    sof   = 1'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] cw, input logic [3:0] p, input int maxgap);
    poly = p;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (maxgap > 0) idle($urandom_range(maxgap, 0));
      send_bit(cw[i], i == LEN - 1);
      poly = 4'($urandom);
    end
  endtask

  task automatic check_result(input logic ok, input logic [2:0] syn, input logic [4:0] d);
    check("done_latency", done, 1'b1);
    check("crc_ok", crc_ok, ok);
    check("syndrome", syndrome, syn);
    check("data", data, d);
    check("ready_in_done", ready, 1'b0);
  endtask

  initial begin
    int d0;
    int f0;
    logic [4:0] rd;
    logic [3:0] rp;
    logic [2:0] rc;
    logic [7:0] cw;
    logic [2:0] esyn;
    logic       flip;

    rst   = 1'b1;
    valid = 1'b0;
    bitv  = 1'b0;
    sof   = 1'b0;
    poly  = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_crc_ok", crc_ok, 1'b0);
    check("rst_syndrome", syndrome, 3'b000);
    check("rst_data", data, 5'b00000);
    check("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    idle(2);

    // Good frame, back-to-back bits
    send_frame(8'b11010_010, 4'b1011, 0);
    check_result(1'b1, 3'b000, 5'b11010);
    idle(1);
    check("done_one_cycle", done, 1'b0);
    check("ready_after_done", ready, 1'b1);
    check("held_crc_ok", crc_ok, 1'b1);

    // Corrupt frame
    send_frame(8'b11010_011, 4'b1011, 0);
    check_result(1'b0, 3'b001, 5'b11010);
    idle(2);

    // Pre-SOF drops followed by a good frame with gaps
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0);
    check("busy_pre_sof", busy, 1'b0);
    send_frame(8'b11010_010, 4'b1011, 3);
    check_result(1'b1, 3'b000, 5'b11010);
    idle(2);

    // Early SOF aborts a partial frame
    f0 = ferr_cnt;
    poly = 4'b1011;
    send_bit(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0);
    cw = 8'b11010_010;
    send_bit(cw[7], 1'b1);
    check("frame_err_pulse", frame_err, 1'b1);
    check("busy_after_restart", busy, 1'b1);
    poly = 4'($urandom);
    for (int i = LEN - 2; i >= 0; i--) send_bit(cw[i], 1'b0);
    check_result(1'b1, 3'b000, 5'b11010);
    idle(2);
    check("frame_err_count", ferr_cnt - f0, 1);

    // Reset mid-frame clears held outputs and suppresses o_done
    d0 = done_cnt;
    poly = 4'b1011;
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_crc_ok", crc_ok, 1'b0);
    check("midrst_syndrome", syndrome, 3'b000);
    check("midrst_data", data, 5'b00000);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
    idle(LEN + 2);
    check("midrst_no_done", done_cnt - d0, 0);

    // Randomized frames with occasional single-bit flips
    for (int n = 0; n < 1000; n++) begin
      rd   = 5'($urandom);
      rp   = {1'b1, 3'($urandom)};
      rc   = ref_rem({rd, 3'b000}, rp);
      cw   = {rd, rc};
      flip = ($urandom_range(9, 0) == 0);
      if (flip) cw = cw ^ (8'd1 << $urandom_range(7, 0));
      esyn = ref_rem(cw, rp);
      send_frame(cw, rp, ($urandom_range(1, 0) == 1) ? 2 : 0);
      check("rnd_done", done, 1'b1);
      check("rnd_crc_ok", crc_ok, esyn == 3'b000);
      check("rnd_syndrome", syndrome, esyn);
      check("rnd_data", data, cw[7:3]);
      if (flip && rp[0]) check("rnd_flip_detected", crc_ok, 1'b0);
    end
    idle(3);

    check("ready_low_only_in_done", ready_bad, 0);
    check("done_pulse_total", done_cnt, 1004);
    check("frame_err_total", ferr_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
